mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch port and the data-memory port of the 16-bit processor.
- Serializes the two ports' accesses, stalls whichever requester is not being serviced, and traps memory hangs on err.
- Sits between the fetch and data-memory units and the memory model; proc ORs its err into the top-level err.

Parameters:
- ADDR_W, 16, address width of all ports
- DATA_W, 16, data width of all ports
- TIMEOUT, 32, max cycles in an access state waiting for mem_ack before error (must be >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request (level, held until if_done)
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction, valid when if_done
- if_done  output  1  one-cycle fetch completion pulse
- if_stall  output  1  if_req && !if_done
- dm_req  input  1  data request (level, held until dm_done)
- dm_wr  input  1  1 = write, 0 = read
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  write data
- dm_rdata  output  DATA_W  read data, valid when dm_done on a read
- dm_done  output  1  one-cycle data completion pulse
- dm_stall  output  1  dm_req && !dm_done
- mem_req  output  1  memory access strobe, held until mem_ack
- mem_wr  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_ack  input  1  one-cycle completion from memory
- mem_rdata  input  DATA_W  read data, valid with mem_ack
- err  output  1  sticky timeout error

Behaviour:
- States: IDLE, IF_ACC, DM_ACC, RESP, ERR.
- Reset (rst low, async): state IDLE, all outputs 0, last_dm = 0, timeout counter 0, if_rdata/dm_rdata 0.
- IDLE arbitration:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant the port not served last (last_dm = 1 -> fetch, else data), so back-to-back contention alternates. After reset, the data port wins a tie.
  - Neither: stay in IDLE.
- Grant: latch addr/wr/wdata into registers, go to IF_ACC/DM_ACC, assert mem_req next cycle, clear the counter. mem_addr/mem_wr/mem_wdata are driven from the latched values and stay stable for the whole access. Fetch accesses drive mem_wr = 0.
- In ACC with mem_ack = 0: counter increments. When counter reaches TIMEOUT-1 without ack, go to ERR.
- In ACC with mem_ack = 1: register mem_rdata into if_rdata or dm_rdata (reads only), drop mem_req, go to RESP, update last_dm.
- RESP (1 cycle): pulse if_done or dm_done for the served port, then IDLE.
- Latency: req seen in IDLE at cycle 0 -> mem_req at 1 -> mem_ack at k (k >= 1) -> done at k+1 -> next grant evaluated at k+2. Best case 3 cycles/access.
- Writes: dm_done pulses and dm_rdata holds its previous value.
- Ports drop req the cycle after done or present a new request. Any req high in IDLE is a new request.
- Req deasserted mid-access: the access still completes and done still pulses.
- mem_ack while not in ACC: ignored.
- ERR: err = 1, mem_req = 0, no done pulses, stalls follow req. Leave only via reset.
- Reset mid-access: immediate return to IDLE, mem_req drops asynchronously, no done pulse.

Test Plan:
- Fetch only: if_addr = 0x0010, memory acks 2 cycles after mem_req with 0xA5A5 -> mem_addr = 0x0010, mem_wr = 0, if_done one cycle after ack, if_rdata = 0xA5A5, dm_done never asserted.
- Simultaneous req from reset: if_req and dm_req (read 0x0200) at the same edge -> data served first, fetch granted in the IDLE after RESP. With both held continuously, grants alternate D,F,D,F.
- Data write: dm_wr = 1, dm_addr = 0x0300, dm_wdata = 0x1234 -> mem_wr = 1, mem_wdata = 0x1234 stable until ack, dm_done pulses, dm_rdata unchanged, if_stall high throughout if if_req is high.
- Timeout: TIMEOUT = 32, no mem_ack -> err rises 32 cycles after entering ACC, mem_req drops, err stays 1 until rst low.
- Reset mid-access: pull rst low while mem_req = 1 -> mem_req, done and err go 0 immediately. After release, a fresh if_req is granted normally.
- Stray ack: mem_ack pulsed in IDLE -> no done, no state change, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one variable-latency memory between the fetch port and
//                the data port; round-robin on contention, sticky timeout error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    // data-memory port
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    // unified memory
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // sticky timeout error
    output logic              err
);

    localparam int              c_CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF_ACC = 3'd1,
        S_DM_ACC = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_in_acc;
    logic                r_last_dm;
    logic                r_srv_dm;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    assign w_in_acc = (r_state == S_IF_ACC) || (r_state == S_DM_ACC);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and grant decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the port that was not served last wins
                if (dm_req && (!if_req || !r_last_dm)) begin
                    w_grant_dm = 1'b1;
                    w_next     = S_DM_ACC;
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                    w_next     = S_IF_ACC;
                end
            end
            S_IF_ACC, S_DM_ACC: begin
                if (mem_ack) begin
                    w_next = S_RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_RESP:  w_next = S_IDLE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Access latch, timeout counter, read-data capture, fairness flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_srv_dm   <= 1'b0;
            r_cnt      <= '0;
            r_last_dm  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_grant_dm) begin
                r_addr   <= dm_addr;
                r_wr     <= dm_wr;
                r_wdata  <= dm_wdata;
                r_srv_dm <= 1'b1;
                r_cnt    <= '0;
            end else if (w_grant_if) begin
                r_addr   <= if_addr;
                r_wr     <= 1'b0;
                r_wdata  <= '0;
                r_srv_dm <= 1'b0;
                r_cnt    <= '0;
            end else if (w_in_acc) begin
                if (mem_ack) begin
                    r_last_dm <= r_srv_dm;
                    if (!r_srv_dm) begin
                        r_if_rdata <= mem_rdata;
                    end else if (!r_wr) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from state so a reset drops them immediately
    // ------------------------------------------------------------------------
    assign mem_req   = w_in_acc;
    assign mem_wr    = w_in_acc && r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_done   = (r_state == S_RESP) && !r_srv_dm;
    assign dm_done   = (r_state == S_RESP) &&  r_srv_dm;
    assign if_stall  = if_req && !if_done;
    assign dm_stall  = dm_req && !dm_done;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter with a behavioural memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_wr, mem_ack;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_req, mem_wr, err;

    typedef struct {
        bit          dm;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    bit          last_done_dm = 1'b0;
    logic [15:0] exp_if_rd = '0;
    logic [15:0] exp_dm_rd = '0;
    // memory model controls
    bit          mem_en = 1'b1;
    int          ack_delay = 2;
    int          stray_cnt = 0;
    int          stray_seen = 0;
    bit          m_active = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr, m_wdata;
    logic        m_wr;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit dm, input bit wr, input logic [15:0] addr, input logic [15:0] wd);
        txn_t t;
        t.dm = dm; t.wr = wr; t.addr = addr; t.wdata = wd; t.data = mem_val(addr);
        exp_q.push_back(t);
    endtask

    // Memory model and completion monitor, both sampled on the falling edge
    initial begin
        txn_t e;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ack  = 1'b0;
                m_active = 1'b0;
            end else begin
                check("if_stall", if_stall, if_req && !if_done);
                check("dm_stall", dm_stall, dm_req && !dm_done);
                if (if_done || dm_done) begin
                    check("one_done", if_done && dm_done, 1'b0);
                    n_done = n_done + 1;
                    done_cyc = cyc;
                    last_done_dm = dm_done;
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_port", dm_done, e.dm);
                        if (!e.dm) begin
                            check("if_rdata", if_rdata, e.data);
                            exp_if_rd = e.data;
                        end else if (e.wr) begin
                            check("dm_rdata_hold", dm_rdata, exp_dm_rd);
                        end else begin
                            check("dm_rdata", dm_rdata, e.data);
                            exp_dm_rd = e.data;
                        end
                    end
                end
                if (stray_cnt != stray_seen) begin
                    stray_seen = stray_cnt;
                    mem_ack    = 1'b1;
                    mem_rdata  = 16'hDEAD;
                end else if (mem_req && mem_en) begin
                    if (!m_active) begin
                        m_active = 1'b1;
                        m_cnt    = 0;
                        m_addr   = mem_addr;
                        m_wr     = mem_wr;
                        m_wdata  = mem_wdata;
                        if (exp_q.size() > 0) begin
                            check("mem_addr", mem_addr, exp_q[0].addr);
                            check("mem_wr", mem_wr, exp_q[0].wr);
                            if (exp_q[0].wr) check("mem_wdata", mem_wdata, exp_q[0].wdata);
                        end
                    end else begin
                        check("addr_stable", mem_addr, m_addr);
                        check("wr_stable", mem_wr, m_wr);
                        check("wdata_stable", mem_wdata, m_wdata);
                    end
                    if (m_cnt == ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_val(mem_addr);
                    end else begin
                        mem_ack = 1'b0;
                        m_cnt   = m_cnt + 1;
                    end
                end else begin
                    mem_ack = 1'b0;
                    if (!mem_req) m_active = 1'b0;
                end
            end
        end
    end

    task automatic run_single(input bit dm, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wd, input int dly, output int lat);
        int base, c0, g;
        ack_delay = dly;
        @(posedge clk); #1;
        push(dm, wr, addr, wd);
        base = n_done;
        c0   = cyc;
        if (dm) begin
            dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        g = 0;
        while (n_done == base && g < 200) begin
            @(posedge clk);
            g = g + 1;
        end
        #1;
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        if (n_done == base) begin
            check("done_timeout", 1'b0, 1'b1);
            lat = -1;
        end else begin
            lat = done_cyc - c0;
        end
    endtask

    // Both ports request together; each re-requests until served reps times
    task automatic contend(input int reps, input bit dwr, input logic [15:0] dbase,
                           input logic [15:0] fbase);
        int nd, nf, base, g;
        ack_delay = 1;
        @(posedge clk); #1;
        push(1'b1, dwr, dbase, 16'h1234);
        push(1'b0, 1'b0, fbase, 16'h0000);
        dm_req = 1'b1; dm_wr = dwr; dm_addr = dbase; dm_wdata = 16'h1234;
        if_req = 1'b1; if_addr = fbase;
        nd = 0; nf = 0; base = n_done; g = 0;
        while ((nd < reps || nf < reps) && g < 400) begin
            @(posedge clk);
            g = g + 1;
            if (n_done != base) begin
                base = n_done;
                #1;
                if (last_done_dm) begin
                    nd = nd + 1;
                    if (nd < reps) begin
                        dm_addr = dbase + 16'(nd * 16);
                        push(1'b1, dwr, dm_addr, 16'h1234);
                    end else begin
                        dm_req = 1'b0; dm_wr = 1'b0;
                    end
                end else begin
                    nf = nf + 1;
                    if (nf < reps) begin
                        if_addr = fbase + 16'(nf * 16);
                        push(1'b0, 1'b0, if_addr, 16'h0000);
                    end else begin
                        if_req = 1'b0;
                    end
                end
            end
        end
        if (g >= 400) check("contend_timeout", 1'b0, 1'b1);
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    endtask

    initial begin
        int lat, c0, g;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_done", {if_done, dm_done}, 2'b00);
        check("rst_if_rdata", if_rdata, 16'h0000);
        check("rst_dm_rdata", dm_rdata, 16'h0000);
        check("rst_mem_addr", mem_addr, 16'h0000);
        rst = 1'b1;

        // Tie straight out of reset: data first, then alternation D,F,D,F
        contend(2, 1'b0, 16'h0200, 16'h0100);

        // Fetch only, ack two cycles after mem_req
        run_single(1'b0, 1'b0, 16'h0010, 16'h0000, 2, lat);
        check("if_latency", lat, 4);
        check("if_rdata_a5a5", if_rdata, 16'hA5A5);

        // Data write while the fetch port also waits
        contend(1, 1'b1, 16'h0300, 16'h0020);

        // Minimum-latency data read (ack in the first mem_req cycle)
        run_single(1'b1, 1'b0, 16'h0600, 16'h0000, 0, lat);
        check("dm_latency_min", lat, 2);

        // Stray ack in IDLE
        @(posedge clk); #1;
        stray_cnt = stray_cnt + 1;
        repeat (3) @(posedge clk);
        #1;
        check("stray_if_rdata", if_rdata, exp_if_rd);
        check("stray_dm_rdata", dm_rdata, exp_dm_rd);
        check("stray_mem_req", mem_req, 1'b0);
        run_single(1'b0, 1'b0, 16'h0030, 16'h0000, 2, lat);
        check("post_stray_latency", lat, 4);

        // Timeout: no ack ever arrives
        mem_en = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0400;
        g = 0;
        while (!err && g < 100) begin
            @(negedge clk);
            g = g + 1;
        end
        check("err_rise_cycle", cyc - c0, 33);
        check("err_mem_req", mem_req, 1'b0);
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1'b1);
        check("err_if_stall", if_stall, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("err_sticky_noreq", err, 1'b1);
        check("err_if_stall_noreq", if_stall, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("err_cleared", err, 1'b0);
        exp_if_rd = '0;
        exp_dm_rd = '0;
        check("rst2_if_rdata", if_rdata, 16'h0000);
        mem_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset in the middle of an access
        mem_en = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0500;
        g = 0;
        while (!mem_req && g < 20) begin
            @(negedge clk);
            g = g + 1;
        end
        check("abort_mem_req_up", mem_req, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_done", {if_done, dm_done}, 2'b00);
        check("abort_err", err, 1'b0);
        if_req = 1'b0;
        mem_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        run_single(1'b0, 1'b0, 16'h0040, 16'h0000, 1, lat);
        check("post_reset_latency", lat, 3);

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
